// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: FIFO bus (master drives clr_i/wr_i/wdata/rd_i; slave returns rdata/rvalid_o/flags/level_o/errors)
interface sync_fifo_flex_if #(
  parameter int DWID = 16,
  parameter int DEP = 8
);
  logic clr_i;
  logic wr_i;
  logic [DWID-1:0] wdata;
  logic rd_i;
  logic [DWID-1:0] rdata;
  logic rvalid_o;
  logic full_o;
  logic empty_o;
  logic afull_o;
  logic aempty_o;
  logic [$clog2(DEP+1)-1:0] level_o;
  logic ovf_err_o;
  logic unf_err_o;
  modport master (
    output clr_i, wr_i, wdata, rd_i,
    input rdata, rvalid_o, full_o, empty_o, afull_o, aempty_o, level_o, ovf_err_o, unf_err_o
  );
  modport slave (
    input clr_i, wr_i, wdata, rd_i,
    output rdata, rvalid_o, full_o, empty_o, afull_o, aempty_o, level_o, ovf_err_o, unf_err_o
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: any-depth sync FIFO (clk, async active-low rst, bus slave: clr/wr/rd in; data, level, flags, sticky errors out)
module sync_fifo_flex #(
  parameter int DWID = 16,
  parameter int DEP = 8,
  parameter int AFULL_TH = DEP - 1,
  parameter int AEMPTY_TH = 1,
  parameter bit FWFT = 1'b1
) (
  input logic clk,
  input logic rst,
  sync_fifo_flex_if.slave bus
);
  localparam int PW = $clog2(DEP);
  localparam int LW = $clog2(DEP + 1);
  localparam logic [LW-1:0] AF = LW'(AFULL_TH);
  localparam logic [LW-1:0] AE = LW'(AEMPTY_TH);
  logic [DWID-1:0] mem [DEP];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic full, empty, rd_acc, wr_acc, ovf, unf, rv;
  logic [DWID-1:0] rd_data;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEP - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = level == LW'(DEP);
  assign empty = level == '0;
  assign rd_acc = bus.rd_i & ~empty;
  assign wr_acc = bus.wr_i & (~full | rd_acc);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (bus.clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= inc(wr_ptr);
      if (rd_acc) rd_ptr <= inc(rd_ptr);
      level <= level + LW'(wr_acc) - LW'(rd_acc);
      ovf <= ovf | (bus.wr_i & ~wr_acc);
      unf <= unf | (bus.rd_i & empty);
    end
  end
  // storage has no reset; a write coinciding with reset or flush is dropped
  always_ff @(posedge clk) begin
    if (rst && !bus.clr_i && wr_acc) mem[wr_ptr] <= bus.wdata;
  end
  if (FWFT) begin : g_fwft
    assign rd_data = mem[rd_ptr];
    assign rv = ~empty;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_data <= '0;
        rv <= 1'b0;
      end else if (bus.clr_i) begin
        rv <= 1'b0;
      end else begin
        rv <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end
  assign bus.rdata = rd_data;
  assign bus.rvalid_o = rv;
  assign bus.full_o = full;
  assign bus.empty_o = empty;
  assign bus.afull_o = level >= AF;
  assign bus.aempty_o = level <= AE;
  assign bus.level_o = level;
  assign bus.ovf_err_o = ovf;
  assign bus.unf_err_o = unf;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed checks of sync_fifo_flex in FWFT (DEP=5, AFULL_TH=4, AEMPTY_TH=1) and registered-read modes
module tb_sync_fifo_flex;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  sync_fifo_flex_if #(.DWID(16), .DEP(5)) a_if ();
  sync_fifo_flex_if #(.DWID(16), .DEP(5)) b_if ();
  sync_fifo_flex #(.DWID(16), .DEP(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(1'b1)) u_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  sync_fifo_flex #(.DWID(16), .DEP(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(1'b0)) u_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] wv(input int i);
    return i == 5 ? 16'h1234 : 16'(32'h100 + i);
  endfunction
  initial begin
    rst = 1'b0;
    a_if.clr_i = 0; a_if.wr_i = 0; a_if.rd_i = 0; a_if.wdata = '0;
    b_if.clr_i = 0; b_if.wr_i = 0; b_if.rd_i = 0; b_if.wdata = '0;
    tick;
    tick;
    chk("rst_level", a_if.level_o, 0);
    chk("rst_empty", a_if.empty_o, 1);
    chk("rst_full", a_if.full_o, 0);
    chk("rst_afull", a_if.afull_o, 0);
    chk("rst_aempty", a_if.aempty_o, 1);
    chk("rst_rvalid", a_if.rvalid_o, 0);
    chk("rst_ovf", a_if.ovf_err_o, 0);
    chk("rst_unf", a_if.unf_err_o, 0);
    chk("rst_b_rdata", b_if.rdata, 0);
    chk("rst_b_rvalid", b_if.rvalid_o, 0);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_if.wr_i = 1; a_if.wdata = 16'(i);
      tick;
      chk("fill_level", a_if.level_o, i);
      chk("fill_afull", a_if.afull_o, i >= 4);
      chk("fill_aempty", a_if.aempty_o, i <= 1);
      chk("fill_full", a_if.full_o, i == 5);
      chk("fill_rvalid", a_if.rvalid_o, 1);
      chk("fill_head", a_if.rdata, 16'h0001);
    end
    a_if.wdata = 16'h0006;
    tick;
    chk("ovf_set", a_if.ovf_err_o, 1);
    chk("ovf_level", a_if.level_o, 5);
    a_if.wr_i = 0; a_if.rd_i = 1;
    for (int k = 1; k <= 5; k++) begin
      chk("drain_rdata", a_if.rdata, k);
      chk("drain_rvalid", a_if.rvalid_o, 1);
      tick;
    end
    chk("drain_empty", a_if.empty_o, 1);
    chk("drain_rvalid0", a_if.rvalid_o, 0);
    chk("drain_unf0", a_if.unf_err_o, 0);
    tick;
    chk("unf_set", a_if.unf_err_o, 1);
    chk("ovf_sticky", a_if.ovf_err_o, 1);
    a_if.rd_i = 0; a_if.wr_i = 1;
    a_if.wdata = 16'h000A; tick;
    a_if.wdata = 16'h000B; tick;
    a_if.wdata = 16'h000C; tick;
    chk("pre_clr_level", a_if.level_o, 3);
    a_if.clr_i = 1; a_if.wdata = 16'hDEAD;
    tick;
    a_if.clr_i = 0; a_if.wr_i = 0;
    chk("clr_level", a_if.level_o, 0);
    chk("clr_empty", a_if.empty_o, 1);
    chk("clr_ovf", a_if.ovf_err_o, 0);
    chk("clr_unf", a_if.unf_err_o, 0);
    chk("clr_rvalid", a_if.rvalid_o, 0);
    tick;
    chk("clr_wr_ignored", a_if.level_o, 0);
    a_if.wr_i = 1; a_if.rd_i = 1; a_if.wdata = 16'h0077;
    tick;
    a_if.wr_i = 0; a_if.rd_i = 0;
    chk("rw_empty_unf", a_if.unf_err_o, 1);
    chk("rw_empty_level", a_if.level_o, 1);
    chk("rw_empty_rdata", a_if.rdata, 16'h0077);
    a_if.clr_i = 1;
    tick;
    a_if.clr_i = 0;
    a_if.wr_i = 1;
    for (int i = 0; i < 5; i++) begin
      a_if.wdata = wv(i);
      tick;
    end
    chk("wrap_full", a_if.full_o, 1);
    a_if.rd_i = 1;
    for (int i = 5; i < 15; i++) begin
      a_if.wdata = wv(i);
      chk("wrap_rdata", a_if.rdata, wv(i - 5));
      tick;
      chk("wrap_level", a_if.level_o, 5);
    end
    chk("wrap_no_ovf", a_if.ovf_err_o, 0);
    a_if.wr_i = 0;
    for (int j = 10; j < 15; j++) begin
      chk("wrap_tail", a_if.rdata, wv(j));
      tick;
    end
    chk("wrap_empty", a_if.empty_o, 1);
    tick;
    chk("pre_rst_unf", a_if.unf_err_o, 1);
    a_if.rd_i = 0; a_if.wr_i = 1; a_if.wdata = 16'h0055;
    tick;
    tick;
    chk("pre_rst_level", a_if.level_o, 2);
    a_if.wdata = 16'h0066;
    #2 rst = 1'b0;
    #1;
    chk("arst_level", a_if.level_o, 0);
    chk("arst_empty", a_if.empty_o, 1);
    chk("arst_aempty", a_if.aempty_o, 1);
    chk("arst_rvalid", a_if.rvalid_o, 0);
    chk("arst_unf", a_if.unf_err_o, 0);
    a_if.wr_i = 0;
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst_level", a_if.level_o, 0);
    b_if.wr_i = 1; b_if.wdata = 16'hAAAA; tick;
    b_if.wdata = 16'hBBBB; tick;
    b_if.wr_i = 0; b_if.rd_i = 1;
    chk("b_rvalid_idle", b_if.rvalid_o, 0);
    tick;
    chk("b_rd1_rdata", b_if.rdata, 16'hAAAA);
    chk("b_rd1_rvalid", b_if.rvalid_o, 1);
    tick;
    b_if.rd_i = 0;
    chk("b_rd2_rdata", b_if.rdata, 16'hBBBB);
    chk("b_rd2_rvalid", b_if.rvalid_o, 1);
    tick;
    chk("b_rvalid_drop", b_if.rvalid_o, 0);
    chk("b_rdata_hold", b_if.rdata, 16'hBBBB);
    chk("b_empty", b_if.empty_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
